// File: rtl/pipe_control.sv
// Control path of a 5-stage in-order pipeline: decodes the ID opcode into
// control bundles, detects load-use hazards and carries the bundles through ID/EX, EX/MEM and MEM/WB.
module pipe_control #(
    parameter int RD_W      = 5,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      inst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    output logic [2:0]       idex_ex_o,
    output logic [RD_W-1:0]  idex_rd_o,
    output logic [2:0]       exmem_mem_o,
    output logic [RD_W-1:0]  exmem_rd_o,
    output logic [1:0]       memwb_wb_o,
    output logic [RD_W-1:0]  memwb_rd_o,
    output logic             stall_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // Control byte layout: {ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, RegWrite, MemtoReg}
    logic [7:0]      w_ctl;
    logic            w_known;
    logic            w_rs2_used;
    logic [RD_W-1:0] w_rd;
    logic [RD_W-1:0] w_rs1;
    logic [RD_W-1:0] w_rs2;
    logic            w_stall;
    logic            w_bubble;

    logic [2:0]       r_idex_ex;
    logic [2:0]       r_idex_mem;
    logic [1:0]       r_idex_wb;
    logic [RD_W-1:0]  r_idex_rd;
    logic [2:0]       r_exmem_mem;
    logic [1:0]       r_exmem_wb;
    logic [RD_W-1:0]  r_exmem_rd;
    logic [1:0]       r_memwb_wb;
    logic [RD_W-1:0]  r_memwb_rd;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_comb begin
        w_ctl      = 8'b0;
        w_known    = 1'b1;
        w_rs2_used = 1'b0;
        case (inst_i[6:0])
            7'b0110011: begin w_ctl = 8'b0_10_000_10; w_rs2_used = 1'b1; end
            7'b0010011: w_ctl = 8'b1_11_000_10;
            7'b0000011: w_ctl = 8'b1_00_010_11;
            7'b0100011: begin w_ctl = 8'b1_00_001_00; w_rs2_used = 1'b1; end
            7'b1100011: begin w_ctl = 8'b0_01_100_00; w_rs2_used = 1'b1; end
            default:    w_known = 1'b0;
        endcase
    end

    assign w_rd  = RD_W'(inst_i[11:7]);
    assign w_rs1 = RD_W'(inst_i[19:15]);
    assign w_rs2 = RD_W'(inst_i[24:20]);

    // rs1 is read by every known opcode, so w_known doubles as rs1-used.
    assign w_stall = (HAZARD_EN != 0) && valid_i && r_idex_mem[1] && (r_idex_rd != '0) &&
                     ((w_known && (w_rs1 == r_idex_rd)) || (w_rs2_used && (w_rs2 == r_idex_rd)));

    // Unknown opcodes are squashed here so they never reach EX.
    assign w_bubble = flush_i || w_stall || !valid_i || !w_known;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex_ex    <= '0;
            r_idex_mem   <= '0;
            r_idex_wb    <= '0;
            r_idex_rd    <= '0;
            r_exmem_mem  <= '0;
            r_exmem_wb   <= '0;
            r_exmem_rd   <= '0;
            r_memwb_wb   <= '0;
            r_memwb_rd   <= '0;
            r_illegal    <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_bubble) begin
                r_idex_ex  <= '0;
                r_idex_mem <= '0;
                r_idex_wb  <= '0;
                r_idex_rd  <= '0;
            end else begin
                r_idex_ex  <= w_ctl[7:5];
                r_idex_mem <= w_ctl[4:2];
                r_idex_wb  <= w_ctl[1:0];
                r_idex_rd  <= w_rd;
            end
            r_exmem_mem <= r_idex_mem;
            r_exmem_wb  <= r_idex_wb;
            r_exmem_rd  <= r_idex_rd;
            r_memwb_wb  <= r_exmem_wb;
            r_memwb_rd  <= r_exmem_rd;
            r_illegal   <= valid_i && !flush_i && !w_known;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (valid_i && (flush_i || w_stall) && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign idex_ex_o    = r_idex_ex;
    assign idex_rd_o    = r_idex_rd;
    assign exmem_mem_o  = r_exmem_mem;
    assign exmem_rd_o   = r_exmem_rd;
    assign memwb_wb_o   = r_memwb_wb;
    assign memwb_rd_o   = r_memwb_rd;
    assign stall_o      = w_stall;
    assign illegal_o    = r_illegal;
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
